fpu: RTL and testbench

FPU -- requirements
Module: fpu

---
 rtl/fpu.sv | 255 +++++++++++++++++++++++++
 tb/tb_fpu.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fpu.sv
// fpu: iterative IEEE-754 binary64 add/subtract/multiply/divide.
// Denormal inputs act as signed zero and tiny results flush to signed zero.
// Results, ready and status flags are all registered and change together.
module fpu (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  rmode,
  input  logic [2:0]  fpu_op,
  input  logic [63:0] opa,
  input  logic [63:0] opb,
  output logic [63:0] out,
  output logic        ready,
  output logic        underflow,
  output logic        overflow,
  output logic        inexact,
  output logic        exception,
  output logic        invalid
);

  typedef enum logic [2:0] {IDLE, UNPACK, COMPUTE, NORMALIZE, ROUND, DONE} state_t;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  state_t             state;
  logic [63:0]        a_r, b_r, spec_out_r;
  logic [2:0]         op_r;
  logic [1:0]         rm_r;
  logic [5:0]         cnt, last, sh_r;
  logic               sign_r, eff_sub, zero_r, spec_r, spec_inv_r, spec_dbz_r;
  logic signed [12:0] exp_r;
  logic [56:0]        acc_r;   // [55] = integer bit, [2:0] = guard/round/sticky
  logic [55:0]        al_r, m_r;
  logic [105:0]       p_r;     // shift-add product: high half accumulates, low half holds multiplier
  logic [53:0]        rem_r;
  logic [54:0]        quo_r;

  logic [10:0] ea, eb;
  logic [51:0] fa, fb;
  logic [52:0] ma, mb;
  logic        sb, sm, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;

  assign ea     = a_r[62:52];
  assign eb     = b_r[62:52];
  assign fa     = a_r[51:0];
  assign fb     = b_r[51:0];
  assign ma     = (ea == 11'd0) ? 53'd0 : {1'b1, fa};
  assign mb     = (eb == 11'd0) ? 53'd0 : {1'b1, fb};
  assign sb     = b_r[63] ^ (op_r == 3'd1);
  assign sm     = a_r[63] ^ b_r[63];
  assign nan_a  = (ea == 11'h7FF) && (fa != 52'd0);
  assign nan_b  = (eb == 11'h7FF) && (fb != 52'd0);
  assign snan_a = nan_a & ~fa[51];
  assign snan_b = nan_b & ~fb[51];
  assign inf_a  = (ea == 11'h7FF) && (fa == 52'd0);
  assign inf_b  = (eb == 11'h7FF) && (fb == 52'd0);
  assign zero_a = (ea == 11'd0);
  assign zero_b = (eb == 11'd0);

  function automatic logic [5:0] lead_zeros(input logic [55:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 56; i++) begin
      if (v[i]) n = 6'(55 - i);
      else      n = n;
    end
    return n;
  endfunction

  function automatic logic [5:0] shift_cap(input logic [10:0] d);
    return (d > 11'd60) ? 6'd60 : d[5:0];
  endfunction

  logic        sp_v, sp_inv, sp_dbz;
  logic [63:0] sp_out;
  // Classify NaN/inf/zero operand combinations that bypass the datapath
  always_comb begin
    sp_v = 1'b0; sp_out = QNAN; sp_inv = 1'b0; sp_dbz = 1'b0;
    case (op_r)
      3'd0, 3'd1: begin
        if (nan_a | nan_b) begin sp_v = 1'b1; sp_inv = snan_a | snan_b; end
        else if (inf_a & inf_b & (a_r[63] != sb)) begin sp_v = 1'b1; sp_inv = 1'b1; end
        else if (inf_a) begin sp_v = 1'b1; sp_out = {a_r[63], 11'h7FF, 52'd0}; end
        else if (inf_b) begin sp_v = 1'b1; sp_out = {sb, 11'h7FF, 52'd0}; end
        else sp_v = 1'b0;
      end
      3'd2: begin
        if (nan_a | nan_b) begin sp_v = 1'b1; sp_inv = snan_a | snan_b; end
        else if ((inf_a & zero_b) | (zero_a & inf_b)) begin sp_v = 1'b1; sp_inv = 1'b1; end
        else if (inf_a | inf_b) begin sp_v = 1'b1; sp_out = {sm, 11'h7FF, 52'd0}; end
        else if (zero_a | zero_b) begin sp_v = 1'b1; sp_out = {sm, 63'd0}; end
        else sp_v = 1'b0;
      end
      3'd3: begin
        if (nan_a | nan_b) begin sp_v = 1'b1; sp_inv = snan_a | snan_b; end
        else if ((inf_a & inf_b) | (zero_a & zero_b)) begin sp_v = 1'b1; sp_inv = 1'b1; end
        else if (inf_a) begin sp_v = 1'b1; sp_out = {sm, 11'h7FF, 52'd0}; end
        else if (inf_b) begin sp_v = 1'b1; sp_out = {sm, 63'd0}; end
        else if (zero_b) begin sp_v = 1'b1; sp_dbz = 1'b1; sp_out = {sm, 11'h7FF, 52'd0}; end
        else if (zero_a) begin sp_v = 1'b1; sp_out = {sm, 63'd0}; end
        else sp_v = 1'b0;
      end
      default: begin sp_v = 1'b1; sp_inv = 1'b1; end
    endcase
  end

  // Final COMPUTE count per operation, fixing each operation's latency
  always_comb begin
    case (op_r)
      3'd2:    last = 6'd54;
      3'd3:    last = 6'd56;
      default: last = 6'd1;
    endcase
  end

  logic [111:0] al_tmp;
  logic [55:0]  al_next;
  logic [53:0]  mul_sum, div_diff;
  logic         div_ge;
  // Next-step values of the alignment shifter, shift-add multiplier and restoring divider
  always_comb begin
    al_tmp   = {al_r, 56'd0} >> sh_r;
    al_next  = {al_tmp[111:57], al_tmp[56] | (|al_tmp[55:0])};
    mul_sum  = {1'b0, p_r[105:53]} + (p_r[0] ? {1'b0, ma} : 54'd0);
    div_ge   = rem_r >= {1'b0, mb};
    div_diff = div_ge ? (rem_r - {1'b0, mb}) : rem_r;
  end

  logic               g_bit, s_bit, inc, to_inf;
  logic [53:0]        mr;
  logic signed [12:0] e_rnd;
  logic [51:0]        frac;
  // Round the normalized mantissa; a carry out bumps the exponent
  always_comb begin
    g_bit = m_r[2];
    s_bit = m_r[1] | m_r[0];
    case (rm_r)
      2'b00:   inc = g_bit & (s_bit | m_r[3]);
      2'b10:   inc = ~sign_r & (g_bit | s_bit);
      2'b11:   inc = sign_r & (g_bit | s_bit);
      default: inc = 1'b0;
    endcase
    mr = {1'b0, m_r[55:3]} + {53'd0, inc};
    if (mr[53]) begin e_rnd = exp_r + 13'sd1; frac = mr[52:1]; end
    else        begin e_rnd = exp_r;          frac = mr[51:0]; end
    to_inf = (rm_r == 2'b00) | ((rm_r == 2'b10) & ~sign_r) | ((rm_r == 2'b11) & sign_r);
  end

  // Operation sequencer with datapath registers and registered result/flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE; a_r <= 64'd0; b_r <= 64'd0; op_r <= 3'd0; rm_r <= 2'd0;
      cnt <= 6'd0; sh_r <= 6'd0; sign_r <= 1'b0; eff_sub <= 1'b0; zero_r <= 1'b0;
      exp_r <= 13'sd0; acc_r <= 57'd0; al_r <= 56'd0; m_r <= 56'd0; p_r <= 106'd0;
      rem_r <= 54'd0; quo_r <= 55'd0; spec_r <= 1'b0; spec_inv_r <= 1'b0;
      spec_dbz_r <= 1'b0; spec_out_r <= 64'd0; out <= 64'd0; ready <= 1'b0;
      underflow <= 1'b0; overflow <= 1'b0; inexact <= 1'b0; exception <= 1'b0; invalid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (enable) begin
            a_r <= opa; b_r <= opb; op_r <= fpu_op; rm_r <= rmode;
            ready <= 1'b0; underflow <= 1'b0; overflow <= 1'b0;
            inexact <= 1'b0; exception <= 1'b0; invalid <= 1'b0;
            state <= UNPACK;
          end else begin
            state <= state;
          end
        end
        UNPACK: begin
          spec_r <= sp_v; spec_out_r <= sp_out; spec_inv_r <= sp_inv; spec_dbz_r <= sp_dbz;
          cnt <= 6'd0; zero_r <= 1'b0;
          case (op_r)
            3'd0, 3'd1: begin
              eff_sub <= a_r[63] ^ sb;
              if ({ea, ma} >= {eb, mb}) begin
                sign_r <= a_r[63]; exp_r <= $signed({2'b00, ea});
                acc_r <= {1'b0, ma, 3'b000}; al_r <= {mb, 3'b000}; sh_r <= shift_cap(ea - eb);
              end else begin
                sign_r <= sb; exp_r <= $signed({2'b00, eb});
                acc_r <= {1'b0, mb, 3'b000}; al_r <= {ma, 3'b000}; sh_r <= shift_cap(eb - ea);
              end
            end
            3'd2: begin
              eff_sub <= 1'b0; sign_r <= sm; p_r <= {53'd0, mb};
              exp_r <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 13'sd1023;
            end
            3'd3: begin
              eff_sub <= 1'b0; sign_r <= sm; rem_r <= {1'b0, ma}; quo_r <= 55'd0;
              exp_r <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 13'sd1023;
            end
            default: begin eff_sub <= 1'b0; sign_r <= 1'b0; end
          endcase
          state <= (op_r > 3'd3) ? ROUND : COMPUTE;
        end
        COMPUTE: begin
          cnt <= cnt + 6'd1;
          case (op_r)
            3'd0, 3'd1: begin
              if (cnt == 6'd0) al_r <= al_next;
              else acc_r <= eff_sub ? (acc_r - {1'b0, al_r}) : (acc_r + {1'b0, al_r});
            end
            3'd2: begin
              if (cnt < 6'd53) p_r <= {mul_sum, p_r[52:1]};
              else acc_r <= {p_r[105:50], |p_r[49:0]};
            end
            3'd3: begin
              if (cnt < 6'd55) begin
                quo_r <= {quo_r[53:0], div_ge};
                rem_r <= {div_diff[52:0], 1'b0};
              end else begin
                acc_r <= {1'b0, quo_r, |rem_r};
              end
            end
            default: acc_r <= acc_r;
          endcase
          state <= (cnt == last) ? NORMALIZE : COMPUTE;
        end
        NORMALIZE: begin
          if (acc_r[56]) begin
            m_r <= {acc_r[56:2], acc_r[1] | acc_r[0]};
            exp_r <= exp_r + 13'sd1;
          end else if (acc_r == 57'd0) begin
            zero_r <= 1'b1;
            sign_r <= eff_sub ? (rm_r == 2'b11) : sign_r;
          end else begin
            m_r <= acc_r[55:0] << lead_zeros(acc_r[55:0]);
            exp_r <= exp_r - $signed({7'd0, lead_zeros(acc_r[55:0])});
          end
          state <= ROUND;
        end
        ROUND: begin
          ready <= 1'b1;
          if (spec_r) begin
            out <= spec_out_r; invalid <= spec_inv_r; exception <= spec_inv_r | spec_dbz_r;
          end else if (zero_r) begin
            out <= {sign_r, 63'd0};
          end else if (e_rnd >= 13'sd2047) begin
            out <= to_inf ? {sign_r, 11'h7FF, 52'd0} : {sign_r, 11'h7FE, {52{1'b1}}};
            overflow <= 1'b1; inexact <= 1'b1; exception <= 1'b1;
          end else if (e_rnd <= 13'sd0) begin
            out <= {sign_r, 63'd0};
            underflow <= 1'b1; inexact <= 1'b1; exception <= 1'b1;
          end else begin
            out <= {sign_r, e_rnd[10:0], frac};
            inexact <= g_bit | s_bit;
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu.sv
// tb_fpu: scoreboard bench for fpu; expected results are queued at issue and
// compared with out, flags and latency when ready rises.
module tb_fpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  rmode = 2'd0;
  logic [2:0]  fpu_op = 3'd0;
  logic [63:0] opa = 64'd0;
  logic [63:0] opb = 64'd0;
  logic [63:0] out;
  logic        ready, underflow, overflow, inexact, exception, invalid;
  logic [4:0]  flags;

  assign flags = {underflow, overflow, inexact, exception, invalid};

  fpu dut (
    .clk(clk), .rst(rst), .enable(enable), .rmode(rmode), .fpu_op(fpu_op),
    .opa(opa), .opb(opb), .out(out), .ready(ready), .underflow(underflow),
    .overflow(overflow), .inexact(inexact), .exception(exception), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  flg;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lat_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 8'd5;
      3'd2:       return 8'd58;
      3'd3:       return 8'd60;
      default:    return 8'd2;
    endcase
  endfunction

  // Issue one operation, disturb inputs while busy, then check against the scoreboard.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] rm,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eo, input logic [4:0] ef);
    exp_t e;
    int   lat;
    e.res = eo; e.flg = ef; e.lat = lat_of(op);
    sb_q.push_back(e);
    @(negedge clk);
    fpu_op = op; rmode = rm; opa = a; opb = b; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    opa = {$urandom, $urandom}; opb = {$urandom, $urandom};
    fpu_op = 3'($urandom_range(0, 7)); rmode = 2'($urandom_range(0, 3));
    chk({tag, "_rdy_clr"}, {63'd0, ready}, 64'd0);
    chk({tag, "_flg_clr"}, {59'd0, flags}, 64'd0);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      enable = (k == 1);
      if (ready) begin
        lat = k;
        break;
      end
    end
    enable = 1'b0;
    e = sb_q.pop_front();
    chk({tag, "_out"}, out, e.res);
    chk({tag, "_flags"}, {59'd0, flags}, {59'd0, e.flg});
    chk({tag, "_lat"}, 64'(lat), {56'd0, e.lat});
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", out, 64'd0);
    chk("reset_rdy", {63'd0, ready}, 64'd0);
    chk("reset_flags", {59'd0, flags}, 64'd0);
    @(negedge clk) rst = 1'b1;

    // flags order: underflow, overflow, inexact, exception, invalid
    run_op("mul_1p5x2",   3'd2, 2'd0, 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000);
    run_op("add_1p2",     3'd0, 2'd0, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000);
    run_op("sub_1m1_rne", 3'd1, 2'd0, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 5'b00000);
    run_op("sub_1m1_rmi", 3'd1, 2'd3, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h8000000000000000, 5'b00000);
    run_op("div_1d3_rne", 3'd3, 2'd0, 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 5'b00100);
    run_op("div_1d3_rpi", 3'd3, 2'd2, 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555556, 5'b00100);
    run_op("div_1d0",     3'd3, 2'd0, 64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 5'b00010);
    run_op("div_0d0",     3'd3, 2'd0, 64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 5'b00011);
    run_op("mul_ovf_rne", 3'd2, 2'd0, 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FF0000000000000, 5'b01110);
    run_op("mul_ovf_rz",  3'd2, 2'd1, 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FEFFFFFFFFFFFFF, 5'b01110);
    run_op("mul_neg",     3'd2, 2'd0, 64'hBFF8000000000000, 64'h4000000000000000, 64'hC008000000000000, 5'b00000);
    run_op("add_tie_rne", 3'd0, 2'd0, 64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3FF0000000000000, 5'b00100);
    run_op("add_tie_rpi", 3'd0, 2'd2, 64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3FF0000000000001, 5'b00100);
    run_op("add_carry",   3'd0, 2'd0, 64'h3FFFFFFFFFFFFFFF, 64'h3CA0000000000000, 64'h4000000000000000, 5'b00100);
    run_op("add_denorm",  3'd0, 2'd0, 64'h0000000000000001, 64'h3FF0000000000000, 64'h3FF0000000000000, 5'b00000);
    run_op("mul_uflow",   3'd2, 2'd0, 64'h0010000000000000, 64'h3FE0000000000000, 64'h0000000000000000, 5'b10110);
    run_op("add_snan",    3'd0, 2'd0, 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'b00011);
    run_op("add_qnan",    3'd0, 2'd0, 64'h7FF8000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'b00000);
    run_op("inf_m_inf",   3'd0, 2'd0, 64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 5'b00011);
    run_op("mul_0xinf",   3'd2, 2'd0, 64'h0000000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 5'b00011);
    run_op("div_1dinf",   3'd3, 2'd0, 64'h3FF0000000000000, 64'h7FF0000000000000, 64'h0000000000000000, 5'b00000);
    run_op("unused_op",   3'd5, 2'd0, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'b00011);
    run_op("sub_neg",     3'd1, 2'd0, 64'h3FF0000000000000, 64'h4008000000000000, 64'hC000000000000000, 5'b00000);

    // Reset in the middle of a multiply
    @(negedge clk);
    fpu_op = 3'd2; rmode = 2'd0; opa = 64'h3FF8000000000000; opb = 64'h4000000000000000; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_out", out, 64'd0);
    chk("rst_mid_rdy", {63'd0, ready}, 64'd0);
    chk("rst_mid_flags", {59'd0, flags}, 64'd0);
    @(negedge clk) rst = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    chk("rst_abort_rdy", {63'd0, ready}, 64'd0);
    run_op("add_after_rst", 3'd0, 2'd0, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
